// File: rtl/aes_if_pkg.sv
// Shared constants and types for the AES Avalon-MM register front end.
// Register indices are word addresses on the Avalon bus.
package aes_if_pkg;

   localparam logic [3:0] KEY0      = 4'd0;
   localparam logic [3:0] ENC0      = 4'd4;
   localparam logic [3:0] DEC0      = 4'd8;
   localparam logic [3:0] START_IDX = 4'd14;
   localparam logic [3:0] DONE_IDX  = 4'd15;

   localparam int unsigned NUM_DATA_REGS = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } aes_if_state_t;

endpackage

// File: rtl/be_reg32.sv
// 32-bit register with per-byte write enables and a full-word load port.
// The load port takes priority over byte writes.
module be_reg32 (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   input  logic        load_i,
   input  logic [31:0] ldata_i,
   output logic [31:0] q_o
);

   logic [31:0] data_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_q <= '0;
      end else if (load_i) begin
         data_q <= ldata_i;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) data_q[8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/aes_avalon_interface.sv
// Avalon-MM register file feeding the AES decryption core: key/ciphertext
// in, plaintext captured on core completion, START/DONE handshake.
//
// state | meaning
// IDLE  | core not started; key/ciphertext writable
// BUSY  | START held to the core, waiting for AES_DONE
// DONE  | plaintext captured, DONE flag set, waiting for START=0
module aes_avalon_interface
   import aes_if_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              AVL_CS,
   input  logic              AVL_READ,
   input  logic              AVL_WRITE,
   input  logic [ADDR_W-1:0] AVL_ADDR,
   input  logic [3:0]        AVL_BYTE_EN,
   input  logic [DATA_W-1:0] AVL_WRITEDATA,
   output logic [DATA_W-1:0] AVL_READDATA,
   output logic [127:0]      AES_KEY,
   output logic [127:0]      AES_MSG_ENC,
   output logic              AES_START,
   input  logic              AES_DONE,
   input  logic [127:0]      AES_MSG_DEC,
   output logic [31:0]       EXPORT_DATA
);

   aes_if_state_t     state_q;
   logic              start_q;
   logic              done_q;
   logic              aes_start_q;
   logic [DATA_W-1:0] readdata_q;
   logic [DATA_W-1:0] readdata_d;
   logic [31:0]       word_q [NUM_DATA_REGS];

   logic wr_en;
   logic rd_en;
   logic cfg_wr;
   logic start_wr;
   logic start_clr;
   logic capture;

   assign wr_en     = AVL_CS & AVL_WRITE;
   assign rd_en     = AVL_CS & AVL_READ;
   assign cfg_wr    = wr_en && (state_q == IDLE);
   assign start_wr  = wr_en && (AVL_ADDR == START_IDX) && AVL_BYTE_EN[0];
   assign start_clr = start_wr && !AVL_WRITEDATA[0];
   // An abort (START cleared) beats a same-cycle completion from the core.
   assign capture   = (state_q == BUSY) && AES_DONE && !start_clr;

   for (genvar i = 0; i < 8; i++) begin : g_cfg
      be_reg32 u_reg (
         .clk_i   (CLK),
         .rst_i   (RESET),
         .be_i    ((cfg_wr && (AVL_ADDR == ADDR_W'(int'(KEY0) + i))) ? AVL_BYTE_EN : 4'b0000),
         .wdata_i (AVL_WRITEDATA),
         .load_i  (1'b0),
         .ldata_i (32'h0),
         .q_o     (word_q[int'(KEY0) + i])
      );
   end

   for (genvar i = 0; i < 4; i++) begin : g_dec
      be_reg32 u_reg (
         .clk_i   (CLK),
         .rst_i   (RESET),
         .be_i    (4'b0000),
         .wdata_i (AVL_WRITEDATA),
         .load_i  (capture),
         .ldata_i (AES_MSG_DEC[127-32*i -: 32]),
         .q_o     (word_q[int'(DEC0) + i])
      );
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= IDLE;
         start_q     <= 1'b0;
         done_q      <= 1'b0;
         aes_start_q <= 1'b0;
      end else begin
         if (start_wr) start_q <= AVL_WRITEDATA[0];
         case (state_q)
            IDLE: begin
               if (start_q && !start_clr) begin
                  state_q     <= BUSY;
                  aes_start_q <= 1'b1;
               end
            end
            BUSY: begin
               if (start_clr) begin
                  state_q     <= IDLE;
                  aes_start_q <= 1'b0;
               end else if (AES_DONE) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               if (start_clr) begin
                  state_q     <= IDLE;
                  done_q      <= 1'b0;
                  aes_start_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               done_q      <= 1'b0;
               aes_start_q <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      readdata_d = '0;
      if (AVL_ADDR == START_IDX) begin
         readdata_d = {{(DATA_W-1){1'b0}}, start_q};
      end else if (AVL_ADDR == DONE_IDX) begin
         readdata_d = {{(DATA_W-1){1'b0}}, done_q};
      end else if (AVL_ADDR < ADDR_W'(NUM_DATA_REGS)) begin
         readdata_d = word_q[AVL_ADDR];
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         readdata_q <= '0;
      end else if (rd_en) begin
         readdata_q <= readdata_d;
      end
   end

   assign AVL_READDATA = readdata_q;
   assign AES_KEY      = {word_q[0], word_q[1], word_q[2], word_q[3]};
   assign AES_MSG_ENC  = {word_q[4], word_q[5], word_q[6], word_q[7]};
   assign AES_START    = aes_start_q;
   assign EXPORT_DATA  = {AES_KEY[127:112], AES_KEY[15:0]};

endmodule
